// File: rtl/mem_access_unit.sv
// Load/store front end for a 1024 x 32 word-addressed data RAM.
// Byte-addressed requests of byte/half/word size; sub-word stores are
// done as read-modify-write, loads are sign- or zero-extended.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | ready for a new request or clear
// RD    | RAM word addressed; load result or RMW merge is registered
// WR    | mem_store high, registered word written at the next edge
// CLR   | mem_clear high for one cycle
// RESP  | resp_valid high for one cycle, then back to IDLE
module mem_access_unit #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              clear_req,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_store,
    output logic              mem_clear,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [2:0] {IDLE, RD, WR, CLR, RESP} state_t;

    state_t      state;
    logic [1:0]  lane;
    logic [1:0]  size;
    logic        we;
    logic        sgn;
    logic [15:0] wdata_lo;

    logic        misaligned;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Strobes come straight from the state register so reset removes them at once.
    assign mem_store = (state == WR);
    assign mem_clear = (state == CLR);

    // Alignment check on the incoming request; size 11 is always an error.
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            2'b11:   misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

    // Lane extraction/extension for loads and lane replacement for RMW stores.
    always_comb begin
        byte_sel = ram_rdata[7:0];
        case (lane)
            2'd1:    byte_sel = ram_rdata[15:8];
            2'd2:    byte_sel = ram_rdata[23:16];
            2'd3:    byte_sel = ram_rdata[31:24];
            default: byte_sel = ram_rdata[7:0];
        endcase
        half_sel = lane[1] ? ram_rdata[31:16] : ram_rdata[15:0];

        case (size)
            2'b00:   load_val = {{24{sgn & byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{16{sgn & half_sel[15]}}, half_sel};
            default: load_val = ram_rdata;
        endcase

        merged = ram_rdata;
        if (size == 2'b00) begin
            case (lane)
                2'd1:    merged[15:8]  = wdata_lo[7:0];
                2'd2:    merged[23:16] = wdata_lo[7:0];
                2'd3:    merged[31:24] = wdata_lo[7:0];
                default: merged[7:0]   = wdata_lo[7:0];
            endcase
        end else if (lane[1]) begin
            merged[31:16] = wdata_lo;
        end else begin
            merged[15:0] = wdata_lo;
        end
    end

    // Sequencer with registered outputs; mem_addr only moves on an accepted RAM access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            lane       <= 2'b00;
            size       <= 2'b00;
            we         <= 1'b0;
            sgn        <= 1'b0;
            wdata_lo   <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state      <= CLR;
                        req_ready  <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                    end else if (req_valid) begin
                        req_ready  <= 1'b0;
                        resp_rdata <= '0;
                        lane       <= req_addr[1:0];
                        size       <= req_size;
                        we         <= req_we;
                        sgn        <= req_signed;
                        wdata_lo   <= req_wdata[15:0];
                        if (misaligned) begin
                            resp_err   <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            resp_err <= 1'b0;
                            mem_addr <= req_addr[ADDR_W-1:2];
                            if (req_we && req_size == 2'b10) begin
                                mem_wdata <= req_wdata;
                                state     <= WR;
                            end else begin
                                state <= RD;
                            end
                        end
                    end
                end
                RD: begin
                    if (we) begin
                        mem_wdata <= merged;
                        state     <= WR;
                    end else begin
                        resp_rdata <= load_val;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                WR, CLR: begin
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit with a behavioural 1024 x 32 RAM attached.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_signed, clear_req;
    logic [1:0]  req_size;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_store, mem_clear;
    logic [31:0] ram_rdata;

    logic [31:0] ram [0:1023];
    logic        tb_wipe;
    int          store_cnt = 0;
    int          clear_cnt = 0;

    int checks = 0;
    int errors = 0;

    int          o_lat;
    logic        o_err;
    logic [31:0] o_rdata;
    logic        o_pulse_ok;
    int          o_stores;
    int          o_clears;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .clear_req(clear_req),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_store(mem_store),
        .mem_clear(mem_clear), .ram_rdata(ram_rdata)
    );

    assign ram_rdata = ram[mem_addr];

    always @(posedge clk) begin
        if (mem_clear || tb_wipe) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 32'h0;
        end else if (mem_store) begin
            ram[mem_addr] <= mem_wdata;
        end
        if (mem_store) store_cnt <= store_cnt + 1;
        if (mem_clear) clear_cnt <= clear_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request (optionally with clear_req) and record latency and response.
    task automatic run_op(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [11:0] addr, input logic [31:0] wd, input logic clr);
        int s0, c0;
        @(negedge clk);
        s0 = store_cnt;
        c0 = clear_cnt;
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        clear_req  = clr;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        clear_req = 1'b0;
        o_lat = 1;
        while (!resp_valid && o_lat < 10) begin
            @(posedge clk);
            #1;
            o_lat++;
        end
        o_err   = resp_err;
        o_rdata = resp_rdata;
        @(posedge clk);
        #1;
        o_pulse_ok = !resp_valid;
        o_stores   = store_cnt - s0;
        o_clears   = clear_cnt - c0;
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [11:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        err;
        logic [31:0] rdata;
        int          stores;
    } vec_t;

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{"st_w_010",    1, 2'b10, 0, 12'h010, 32'h12345678, 2, 0, 32'h0,        1};
        vecs[1]  = '{"ld_w_010",    0, 2'b10, 0, 12'h010, 32'h0,        2, 0, 32'h12345678, 0};
        vecs[2]  = '{"st_b_011",    1, 2'b00, 0, 12'h011, 32'hFFFFFFAB, 3, 0, 32'h0,        1};
        vecs[3]  = '{"ld_w_after_b",0, 2'b10, 0, 12'h010, 32'h0,        2, 0, 32'h1234AB78, 0};
        vecs[4]  = '{"ld_bs_011",   0, 2'b00, 1, 12'h011, 32'h0,        2, 0, 32'hFFFFFFAB, 0};
        vecs[5]  = '{"ld_bu_011",   0, 2'b00, 0, 12'h011, 32'h0,        2, 0, 32'h000000AB, 0};
        vecs[6]  = '{"st_h_012",    1, 2'b01, 0, 12'h012, 32'h55558001, 3, 0, 32'h0,        1};
        vecs[7]  = '{"ld_w_after_h",0, 2'b10, 0, 12'h010, 32'h0,        2, 0, 32'h8001AB78, 0};
        vecs[8]  = '{"ld_hs_012",   0, 2'b01, 1, 12'h012, 32'h0,        2, 0, 32'hFFFF8001, 0};
        vecs[9]  = '{"ld_hu_012",   0, 2'b01, 0, 12'h012, 32'h0,        2, 0, 32'h00008001, 0};
        vecs[10] = '{"ld_bs_013",   0, 2'b00, 1, 12'h013, 32'h0,        2, 0, 32'hFFFFFF80, 0};
        vecs[11] = '{"ld_bu_010",   0, 2'b00, 0, 12'h010, 32'h0,        2, 0, 32'h00000078, 0};
        vecs[12] = '{"err_h_013",   0, 2'b01, 1, 12'h013, 32'h0,        1, 1, 32'h0,        0};
        vecs[13] = '{"err_w_006",   1, 2'b10, 0, 12'h006, 32'hDEADBEEF, 1, 1, 32'h0,        0};
        vecs[14] = '{"err_sz11",    1, 2'b11, 0, 12'h010, 32'hDEADBEEF, 1, 1, 32'h0,        0};
        vecs[15] = '{"ld_w_unchg",  0, 2'b10, 0, 12'h010, 32'h0,        2, 0, 32'h8001AB78, 0};

        rst = 1'b1; tb_wipe = 1'b1;
        req_valid = 0; req_we = 0; req_size = 0; req_signed = 0;
        req_addr = 0; req_wdata = 0; clear_req = 0;
        repeat (2) @(posedge clk);
        #1;
        tb_wipe = 1'b0;
        check("rst_ready",      {31'b0, req_ready},  32'h1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        check("rst_resp_err",   {31'b0, resp_err},   32'h0);
        check("rst_resp_rdata", resp_rdata,          32'h0);
        check("rst_mem_addr",   {22'b0, mem_addr},   32'h0);
        check("rst_mem_wdata",  mem_wdata,           32'h0);
        check("rst_mem_store",  {31'b0, mem_store},  32'h0);
        check("rst_mem_clear",  {31'b0, mem_clear},  32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, 1'b0);
            check({vecs[i].name, "_lat"},    o_lat,                  vecs[i].lat);
            check({vecs[i].name, "_err"},    {31'b0, o_err},         {31'b0, vecs[i].err});
            check({vecs[i].name, "_rdata"},  o_rdata,                vecs[i].rdata);
            check({vecs[i].name, "_pulse"},  {31'b0, o_pulse_ok},    32'h1);
            check({vecs[i].name, "_stores"}, o_stores,               vecs[i].stores);
        end

        // Reset asserted while an RMW byte store sits in RD.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 12'h010; req_wdata = 32'h000000CD;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rd_mem_addr", {22'b0, mem_addr}, 32'h4);
        rst = 1'b1;
        #1;
        check("rstmid_store",  {31'b0, mem_store},  32'h0);
        check("rstmid_ready",  {31'b0, req_ready},  32'h1);
        check("rstmid_valid",  {31'b0, resp_valid}, 32'h0);
        check("rstmid_rdata",  resp_rdata,          32'h0);
        check("rstmid_maddr",  {22'b0, mem_addr},   32'h0);
        check("rstmid_mwdata", mem_wdata,           32'h0);
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_ram4", ram[4], 32'h8001AB78);
        run_op(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 1'b0);
        check("rstmid_ld", o_rdata, 32'h8001AB78);

        // Clear and load requested together: clear wins.
        run_op(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 1'b1);
        check("clr_lat",    o_lat,              2);
        check("clr_err",    {31'b0, o_err},     32'h0);
        check("clr_pulses", o_clears,           1);
        check("clr_pulse",  {31'b0, o_pulse_ok}, 32'h1);
        check("clr_rdata",  o_rdata,            32'h0);
        run_op(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 1'b0);
        check("clr_ld_lat",   o_lat,   2);
        check("clr_ld_rdata", o_rdata, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
